// File: rtl/mem_scan_pkg.sv
// rtl/mem_scan_pkg.sv - shared types and default widths for the memory scan access path
package mem_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Widths shared with the memory-side block so both ends agree by default.
  localparam int DEF_ADDRBITS = 16;
  localparam int DEF_DQBITS   = 32;
  localparam int DEF_LENBITS  = 8;

endpackage

// File: rtl/mem_scan_master.sv
// rtl/mem_scan_master.sv - scan-domain initiator issuing toggle-triggered, time-completed memory accesses
module mem_scan_master
  import mem_scan_pkg::*;
#(
  parameter int ADDRBITS     = DEF_ADDRBITS,
  parameter int DQBITS       = DEF_DQBITS,
  parameter int LENBITS      = DEF_LENBITS,
  parameter int SETUP_CYCLES = 2,
  parameter int WAIT_CYCLES  = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDRBITS-1:0] cmd_addr,
  input  logic [DQBITS-1:0]   cmd_wdata,
  input  logic [LENBITS-1:0]  cmd_len,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DQBITS-1:0]   rsp_rdata,
  output logic [ADDRBITS-1:0] rsp_addr,
  output logic                rsp_last,
  output logic                busy,
  output logic [ADDRBITS-1:0] scan_addr,
  output logic [DQBITS-1:0]   scan_d,
  output logic                scan_wen_n,
  output logic                scan_cen_n,
  output logic                mem_trigger,
  input  logic [DQBITS-1:0]   scan_q
);

  localparam int CNTMAX = (SETUP_CYCLES > WAIT_CYCLES) ? SETUP_CYCLES : WAIT_CYCLES;
  localparam int CNTW   = (CNTMAX > 1) ? $clog2(CNTMAX) : 1;
  localparam logic [CNTW-1:0] SETUP_LOAD = CNTW'(SETUP_CYCLES - 1);
  localparam logic [CNTW-1:0] WAIT_LOAD  = CNTW'(WAIT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [LENBITS-1:0]   rem_q, rem_d;
  logic [ADDRBITS-1:0]  addr_q, addr_d;
  logic [DQBITS-1:0]    data_q, data_d;
  logic                 wen_n_q, wen_n_d;
  logic                 cen_n_q, cen_n_d;
  logic                 trig_q, trig_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DQBITS-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [ADDRBITS-1:0]  rsp_addr_q, rsp_addr_d;
  logic                 rsp_last_q, rsp_last_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wen_n_q     <= 1'b1;
      cen_n_q     <= 1'b1;
      trig_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wen_n_q     <= wen_n_d;
      cen_n_q     <= cen_n_d;
      trig_q      <= trig_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wen_n_d     = wen_n_q;
    cen_n_d     = cen_n_q;
    trig_d      = trig_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          data_d  = cmd_wdata;
          wen_n_d = ~cmd_write;
          cen_n_d = 1'b0;
          rem_d   = cmd_len;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          trig_d  = ~trig_q;
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        // No return handshake: scan_q is assumed settled by the last wait cycle.
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wen_n_q ? scan_q : '0;
          rsp_addr_d  = addr_q;
          rsp_last_d  = (rem_q == '0);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rem_q == '0) begin
            cen_n_d = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            cnt_d   = SETUP_LOAD;
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE) && !RESET;
  assign busy        = (state_q != IDLE);
  assign scan_addr   = addr_q;
  assign scan_d      = data_q;
  assign scan_wen_n  = wen_n_q;
  assign scan_cen_n  = cen_n_q;
  assign mem_trigger = trig_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_last    = rsp_last_q;

endmodule
